// File: rtl/transmit_if.sv
// Byte handshake between the host-side producer and the serial transmitter.
// The producer drives data_in/data_valid; the transmitter answers with ready.
interface transmit_if;
   logic [7:0] data_in;
   logic       data_valid;
   logic       ready;

   modport master (output data_in, output data_valid, input ready);
   modport slave  (input data_in, input data_valid, output ready);
endinterface

// File: rtl/transmit.sv
// 1-start / 8-data (MSB first) / 1-stop serial transmitter fed by a small byte FIFO.
// Frames may run back-to-back: the next byte is popped on the last stop-bit cycle.
module transmit #(
   parameter int CLKS_PER_BIT = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst,
   transmit_if.slave   bus,
   output logic        txd,
   output logic        busy,
   output logic        word_sent,
   output logic        overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state_reg;
   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_reg;
   logic [AW-1:0]   rd_ptr_reg;
   logic [AW:0]     count_reg;
   logic [7:0]      shift_reg;
   logic [TW-1:0]   timer_reg;
   logic [2:0]      bit_reg;
   logic            push;
   logic            pop;
   logic            bit_done;

   assign bus.ready = (count_reg < (AW+1)'(FIFO_DEPTH));
   assign push      = bus.data_valid && bus.ready;
   assign bit_done  = (timer_reg == TW'(CLKS_PER_BIT - 1));
   // The shifter only loads from IDLE or at the very end of a stop bit.
   assign pop       = (count_reg != '0) &&
                      ((state_reg == IDLE) || ((state_reg == STOP) && bit_done));
   assign busy      = (state_reg != IDLE);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= bus.data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         txd        <= 1'b1;
         word_sent  <= 1'b0;
         overflow   <= 1'b0;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         shift_reg  <= '0;
         timer_reg  <= '0;
         bit_reg    <= '0;
      end else begin
         word_sent <= 1'b0;
         if (bus.data_valid && !bus.ready) begin
            overflow <= 1'b1;
         end
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
            shift_reg  <= mem[rd_ptr_reg];
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase

         case (state_reg)
            IDLE: begin
               txd       <= 1'b1;
               timer_reg <= '0;
               if (pop) begin
                  txd       <= 1'b0;
                  state_reg <= START;
               end
            end
            START: begin
               if (bit_done) begin
                  timer_reg <= '0;
                  bit_reg   <= '0;
                  txd       <= shift_reg[7];
                  state_reg <= DATA;
               end else begin
                  timer_reg <= timer_reg + TW'(1);
               end
            end
            DATA: begin
               if (bit_done) begin
                  timer_reg <= '0;
                  if (bit_reg == 3'd7) begin
                     txd       <= 1'b1;
                     state_reg <= STOP;
                  end else begin
                     shift_reg <= {shift_reg[6:0], 1'b0};
                     txd       <= shift_reg[6];
                     bit_reg   <= bit_reg + 3'd1;
                  end
               end else begin
                  timer_reg <= timer_reg + TW'(1);
               end
            end
            STOP: begin
               if (bit_done) begin
                  timer_reg <= '0;
                  word_sent <= 1'b1;
                  if (pop) begin
                     txd       <= 1'b0;
                     state_reg <= START;
                  end else begin
                     txd       <= 1'b1;
                     state_reg <= IDLE;
                  end
               end else begin
                  timer_reg <= timer_reg + TW'(1);
               end
            end
            default: begin
               txd       <= 1'b1;
               state_reg <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_transmit.sv
// Drives two transmitters (1 and 4 clocks per bit) with identical stimulus and
// compares every output each cycle against a frame-level reference model.
module tb_transmit;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din;
   logic       dval;
   logic       checking;
   int         total = 0;
   int         passed = 0;

   logic txd1, busy1, ws1, ov1;
   logic txd4, busy4, ws4, ov4;

   transmit_if bus1 ();
   transmit_if bus4 ();

   assign bus1.data_in    = din;
   assign bus1.data_valid = dval;
   assign bus4.data_in    = din;
   assign bus4.data_valid = dval;

   transmit #(.CLKS_PER_BIT(1), .FIFO_DEPTH(DEPTH)) u_dut1 (
      .clk(clk), .rst(rst), .bus(bus1),
      .txd(txd1), .busy(busy1), .word_sent(ws1), .overflow(ov1)
   );
   transmit #(.CLKS_PER_BIT(4), .FIFO_DEPTH(DEPTH)) u_dut4 (
      .clk(clk), .rst(rst), .bus(bus4),
      .txd(txd4), .busy(busy4), .word_sent(ws4), .overflow(ov4)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, got, exp);
      end else begin
         passed++;
      end
   endtask

   // Reference model: queue of waiting bytes plus the byte on the line and
   // how many cycles of its 10-bit frame have elapsed.
   logic [7:0] fifo [2][8];
   int         cnt  [2];
   logic [7:0] cur  [2];
   int         pos  [2];
   logic       act  [2];
   logic       e_txd[2];
   logic       e_ws [2];
   logic       e_ov [2];
   int         cp;
   int         pre;

   function automatic logic frame_bit(input logic [7:0] b, input int idx);
      logic [7:0] v;
      v = b;
      if (idx == 0) return 1'b0;
      if (idx >= 9) return 1'b1;
      return v[8 - idx];
   endfunction

   initial begin
      for (int i = 0; i < 2; i++) begin
         cnt[i] = 0; act[i] = 0; pos[i] = 0; cur[i] = 0;
         e_txd[i] = 1; e_ws[i] = 0; e_ov[i] = 0;
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         cp = (i == 0) ? 1 : 4;
         if (rst) begin
            cnt[i] = 0; act[i] = 0; pos[i] = 0;
            e_txd[i] = 1; e_ws[i] = 0; e_ov[i] = 0;
         end else begin
            pre = cnt[i];
            e_ws[i] = 0;
            if (act[i]) begin
               pos[i]++;
               if (pos[i] == 10 * cp) begin
                  e_ws[i] = 1;
                  act[i]  = 0;
               end
            end
            if (!act[i] && pre > 0) begin
               cur[i] = fifo[i][0];
               for (int k = 0; k < 7; k++) fifo[i][k] = fifo[i][k+1];
               cnt[i]--;
               act[i] = 1;
               pos[i] = 0;
            end
            if (dval) begin
               if (pre < DEPTH) begin
                  fifo[i][cnt[i]] = din;
                  cnt[i]++;
               end else begin
                  e_ov[i] = 1;
               end
            end
            e_txd[i] = act[i] ? frame_bit(cur[i], pos[i] / cp) : 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (checking) begin
         check("txd_c1",   32'(txd1),        32'(e_txd[0]));
         check("busy_c1",  32'(busy1),       32'(act[0]));
         check("ws_c1",    32'(ws1),         32'(e_ws[0]));
         check("ovf_c1",   32'(ov1),         32'(e_ov[0]));
         check("ready_c1", 32'(bus1.ready),  32'(cnt[0] < DEPTH));
         check("txd_c4",   32'(txd4),        32'(e_txd[1]));
         check("busy_c4",  32'(busy4),       32'(act[1]));
         check("ws_c4",    32'(ws4),         32'(e_ws[1]));
         check("ovf_c4",   32'(ov4),         32'(e_ov[1]));
         check("ready_c4", 32'(bus4.ready),  32'(cnt[1] < DEPTH));
      end
   end

   task automatic send(input logic [7:0] b);
      din  = b;
      dval = 1'b1;
      @(negedge clk);
      dval = 1'b0;
   endtask

   task automatic wait_idle();
      int quiet;
      quiet = 0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         quiet = (!busy1 && !busy4) ? quiet + 1 : 0;
         if (quiet >= 3) return;
      end
      check("idle_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      din = 8'h00; dval = 1'b0; rst = 1'b1; checking = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checking = 1'b1;
      rst = 1'b0;
      repeat (20) @(negedge clk);

      send(8'hA5);
      wait_idle();

      din = 8'h3C; dval = 1'b1; @(negedge clk);
      din = 8'hFF; @(negedge clk);
      din = 8'h00; @(negedge clk);
      dval = 1'b0;
      wait_idle();

      for (int k = 0; k < 6; k++) begin
         din = 8'h10 + 8'(k); dval = 1'b1; @(negedge clk);
      end
      dval = 1'b0;
      wait_idle();

      send(8'h81);
      wait_idle();

      for (int c = 0; c < 400; c++) begin
         din  = 8'($urandom);
         dval = ($urandom_range(0, 5) == 0);
         @(negedge clk);
      end
      dval = 1'b0;
      wait_idle();

      din = 8'hC3; dval = 1'b1; @(negedge clk);
      din = 8'h5A; @(negedge clk);
      din = 8'h99; @(negedge clk);
      dval = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);

      send(8'h6E);
      wait_idle();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog t=%0t got=running expected=finished", $time);
      $fatal(1);
   end
endmodule
